uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, run-time parity and stop-bit selection, and configurable data width. It accepts bytes from the host-side write strobe and serialises them onto `TxD` back-to-back without idle gaps, framing each one as start, data LSB-first, optional parity, then one or two stop bits. It supersedes the fixed 8-bit, even-parity, single-entry transmitter in the UART path and pairs with the existing receiver.

## Interface
- `DATA_W`, 8: data bits per frame, legal range 5..9.
- `FIFO_DEPTH`, 4: transmit FIFO entries, power of two, at least 2.
- `CLK_HZ`, 50_000_000: system clock frequency, used only to build the divisor table.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Tx_DATA`  in  DATA_W  word to enqueue.
- `Tx_WR`  in  1  enqueue strobe; one word per cycle high.
- `Tx_EN`  in  1  transmit enable; gates the start of new frames only.
- `baud_select`  in  3  rate: 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud for codes 000..111.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
- `stop2`  in  1  0 selects one stop bit, 1 selects two.
- `TxD`  out  1  serial line, idle high, registered.
- `Tx_BUSY`  out  1  high while a frame is on the line.
- `Tx_FULL`  out  1  FIFO holds FIFO_DEPTH words.
- `Tx_EMPTY`  out  1  FIFO holds no words.
- `Tx_OVF`  out  1  one-cycle pulse when a write is dropped.

## Operation
- Reset (`reset`=0, asynchronous): `TxD`=1, `Tx_BUSY`=0, `Tx_FULL`=0, `Tx_EMPTY`=1, `Tx_OVF`=0. The FIFO is emptied, the FSM goes to IDLE and the baud counter clears. A reset during a frame truncates it, and the line returns high immediately.
- Write handling:
  - `Tx_WR`=1 with `Tx_FULL`=0 enqueues `Tx_DATA`.
  - `Tx_WR`=1 with `Tx_FULL`=1 drops the word and pulses `Tx_OVF`. This holds even if a pop happens in the same cycle, because fullness comes from the registered count.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE to START: when `Tx_EN`=1 and `Tx_EMPTY`=0. On this transition the FSM pops the head word and latches `parity_mode`, `stop2` and `baud_select` for the whole frame.
  - START to DATA: after 1 bit time.
  - DATA: lasts DATA_W bit times, driving bit index 0..DATA_W-1. It exits to PARITY if the latched mode is not 00, otherwise to STOP.
  - PARITY to STOP: after 1 bit time. The parity bit is ^data for even, ~^data for odd, 1 for mark.
  - STOP: lasts 1 or 2 bit times. At the end it goes to START (popping the next word) if `Tx_EN`=1 and the FIFO is non-empty, otherwise to IDLE.
- `Tx_EN` low mid-frame does not abort the frame. The current frame completes and no further frame starts. Writes are still accepted.
- Changes on the configuration inputs (`parity_mode`, `stop2`, `baud_select`) mid-frame take effect at the next frame.
- `Tx_BUSY` = (state != IDLE).

## Timing
- One bit time = DIV clocks exactly, where DIV = round(CLK_HZ/baud) for the latched `baud_select`. At 50 MHz, code 111 gives DIV=434 and code 000 gives DIV=166667; the counter is 18 bits.
- The baud counter restarts at 0 on every entry to START, so each frame is aligned to its own start and there is no drift between frames.
- Latency:
  - `Tx_WR` sampled high at edge k into an empty FIFO, FSM idle, `Tx_EN`=1: `Tx_EMPTY` falls after edge k+1 and `TxD` falls after edge k+2.
  - `Tx_BUSY` rises on the same edge that `TxD` falls.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop bit's DIV clocks, with zero idle clocks between frames.
- Frame length = (1 + DATA_W + P + S)·DIV clocks, where P=1 if parity is enabled (else 0) and S=1 or 2.

## Structure
- Package `uart_pkg` holds:
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK;
  - FSM state enum;
  - the `baud_select`-to-divisor function of CLK_HZ.
- Sub-module `uart_sync_fifo` (DATA_W, FIFO_DEPTH): count-based flags and registered `full`/`empty`. It is reused later on the receive side.
- The top module contains the FSM, bit counter, baud counter, shift register and parity generation.

## Test plan
- Single word, DATA_W=8, 0xA5, baud 111, parity even, 1 stop → `TxD` low 434 clk, then 1,0,1,0,0,1,0,1, parity 0, stop 1 (434 clk each), then idle high. `Tx_BUSY` high for exactly 4774 clk.
- Four writes on consecutive cycles (0x00, 0xFF, 0x55, 0x0F) with FIFO_DEPTH=4, odd parity, two stops → four contiguous 12-bit frames with no gap. Parity bits are 1, 1, 1, 1. `Tx_FULL` is never asserted, because the first pop happens before the fourth write.
- Six writes in consecutive cycles while `Tx_EN`=0 → `Tx_FULL` after the 4th write. Writes 5 and 6 each give a one-cycle `Tx_OVF` and are dropped. Raising `Tx_EN` then yields exactly four frames.
- `Tx_EN` dropped during bit D3 → the frame completes normally, `TxD` stays high afterwards, and the queued word waits until `Tx_EN` returns.
- `reset` asserted mid-DATA → on the same cycle, asynchronously, `TxD`=1, `Tx_BUSY`=0 and `Tx_EMPTY`=1. After release, no residual frame is sent.
- DATA_W=5, parity none, 1 stop, 0x13 → 7-bit frame: start 0, bits 1,1,0,0,1, stop 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, transmitter FSM states and the
// baud_select-to-divisor table derived from the system clock frequency.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam int BAUD_CNT_W = 18;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Each branch folds to a constant, so only an 8-entry mux is built.
    function automatic logic [BAUD_CNT_W-1:0] baud_divisor(input logic [2:0] sel,
                                                           input int clk_hz);
        logic [BAUD_CNT_W-1:0] div;
        case (sel)
            3'd0:    div = BAUD_CNT_W'((clk_hz + 150) / 300);
            3'd1:    div = BAUD_CNT_W'((clk_hz + 600) / 1200);
            3'd2:    div = BAUD_CNT_W'((clk_hz + 2400) / 4800);
            3'd3:    div = BAUD_CNT_W'((clk_hz + 4800) / 9600);
            3'd4:    div = BAUD_CNT_W'((clk_hz + 9600) / 19200);
            3'd5:    div = BAUD_CNT_W'((clk_hz + 19200) / 38400);
            3'd6:    div = BAUD_CNT_W'((clk_hz + 28800) / 57600);
            default: div = BAUD_CNT_W'((clk_hz + 57600) / 115200);
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with count-based, registered full/empty flags and a
// one-cycle overflow pulse for writes that arrive while full.
module uart_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              push;
    logic              pop;

    // Fullness is judged on the registered flag, so a same-cycle pop never rescues a write.
    always_comb begin
        push       = wr_en && !full;
        pop        = rd_en && !empty;
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
            ovf   <= wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames go out back-to-back with
// per-frame latched parity, stop-bit count and baud rate.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_HZ     = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Tx_DATA,
    input  logic              Tx_WR,
    input  logic              Tx_EN,
    input  logic [2:0]        baud_select,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              TxD,
    output logic              Tx_BUSY,
    output logic              Tx_FULL,
    output logic              Tx_EMPTY,
    output logic              Tx_OVF
);

    localparam logic [3:0]            LAST_BIT = 4'(DATA_W - 1);
    localparam logic [BAUD_CNT_W-1:0] BAUD_ONE = 1;

    logic                  wr_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     head;
    tx_state_t             state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [BAUD_CNT_W-1:0] div_q;
    logic [3:0]            bit_cnt;
    logic [DATA_W-1:0]     shreg;
    logic [1:0]            par_q;
    logic                  stop2_q;
    logic                  par_bit;
    logic                  next_par;
    logic                  bit_done;
    logic                  last_stop;
    logic                  launch;

    // Host writes are registered once before reaching the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= 1'b0;
            data_q <= '0;
        end else begin
            wr_q   <= Tx_WR;
            data_q <= Tx_DATA;
        end
    end

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_q),
        .wr_data (data_q),
        .rd_en   (launch),
        .rd_data (head),
        .full    (Tx_FULL),
        .empty   (Tx_EMPTY),
        .ovf     (Tx_OVF)
    );

    always_comb begin
        bit_done  = (baud_cnt == div_q - BAUD_ONE);
        last_stop = (bit_cnt == {3'b000, stop2_q});
        launch    = 1'b0;
        if (Tx_EN && !Tx_EMPTY) begin
            if (state == IDLE) begin
                launch = 1'b1;
            end else if (state == STOP && bit_done && last_stop) begin
                launch = 1'b1;
            end
        end
        case (parity_mode)
            PAR_EVEN: next_par = ^head;
            PAR_ODD:  next_par = ~^head;
            default:  next_par = 1'b1;
        endcase
    end

    // Launching a frame overrides whatever the case statement chose, which is
    // how the last stop bit hands over to the next start bit with no idle gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            TxD      <= 1'b1;
            Tx_BUSY  <= 1'b0;
            baud_cnt <= '0;
            div_q    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            if (state != IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + BAUD_ONE;
            end
            case (state)
                IDLE: begin
                    TxD     <= 1'b1;
                    Tx_BUSY <= 1'b0;
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        TxD     <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_q != PAR_NONE) begin
                                state <= PARITY;
                                TxD   <= par_bit;
                            end else begin
                                state <= STOP;
                                TxD   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= shreg >> 1;
                            TxD     <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state   <= STOP;
                        TxD     <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (!last_stop) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            state   <= IDLE;
                            Tx_BUSY <= 1'b0;
                            TxD     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Tx_BUSY <= 1'b0;
                    TxD     <= 1'b1;
                end
            endcase
            if (launch) begin
                state    <= START;
                Tx_BUSY  <= 1'b1;
                TxD      <= 1'b0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= head;
                par_q    <= parity_mode;
                stop2_q  <= stop2;
                par_bit  <= next_par;
                div_q    <= baud_divisor(baud_select, CLK_HZ);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected frames are built from the
// framing rules when words are written, and line monitors check every clock.
module tb_uart_tx_fifo;

    localparam int CLK_HZ_TB = 50_000_000;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_en;
    logic [2:0] baud_select;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       txd, tx_busy, tx_full, tx_empty, tx_ovf;
    logic [4:0] d5_data;
    logic       d5_wr, d5_en;
    logic       d5_txd, d5_busy, d5_full, d5_empty, d5_ovf;

    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    int     frames0 = 0;
    int     frames1 = 0;
    int     ovf_cycles = 0;
    int     full_cycles = 0;
    logic   mon_active0 = 1'b0;
    logic   mon_active1 = 1'b0;
    int     starts0[$];
    frame_t exp0[$];
    frame_t exp1[$];

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_HZ(CLK_HZ_TB)) dut (
        .clk(clk), .reset(reset), .Tx_DATA(tx_data), .Tx_WR(tx_wr), .Tx_EN(tx_en),
        .baud_select(baud_select), .parity_mode(parity_mode), .stop2(stop2),
        .TxD(txd), .Tx_BUSY(tx_busy), .Tx_FULL(tx_full), .Tx_EMPTY(tx_empty), .Tx_OVF(tx_ovf)
    );

    uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(4), .CLK_HZ(CLK_HZ_TB)) dut5 (
        .clk(clk), .reset(reset), .Tx_DATA(d5_data), .Tx_WR(d5_wr), .Tx_EN(d5_en),
        .baud_select(baud_select), .parity_mode(parity_mode), .stop2(stop2),
        .TxD(d5_txd), .Tx_BUSY(d5_busy), .Tx_FULL(d5_full), .Tx_EMPTY(d5_empty), .Tx_OVF(d5_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_ovf) ovf_cycles <= ovf_cycles + 1;
        if (tx_full) full_cycles <= full_cycles + 1;
    end

    // Reference framing: start, data LSB first, optional parity, stop bit(s).
    function automatic frame_t make_frame(input logic [8:0] data, input int w,
                                          input logic [1:0] pm, input logic s2,
                                          input logic [2:0] bsel);
        frame_t f;
        int ones;
        int baud;
        f.bits  = '1;
        f.bits[0] = 1'b0;
        f.nbits = 1;
        ones    = 0;
        for (int i = 0; i < w; i++) begin
            f.bits[f.nbits] = data[i];
            ones += int'(data[i]);
            f.nbits++;
        end
        if (pm != 2'b00) begin
            case (pm)
                2'b01:   f.bits[f.nbits] = (ones % 2 == 1);
                2'b10:   f.bits[f.nbits] = (ones % 2 == 0);
                default: f.bits[f.nbits] = 1'b1;
            endcase
            f.nbits++;
        end
        f.bits[f.nbits] = 1'b1;
        f.nbits++;
        if (s2) begin
            f.bits[f.nbits] = 1'b1;
            f.nbits++;
        end
        case (bsel)
            3'd0: baud = 300;    3'd1: baud = 1200;  3'd2: baud = 4800;
            3'd3: baud = 9600;   3'd4: baud = 19200; 3'd5: baud = 38400;
            3'd6: baud = 57600;  default: baud = 115200;
        endcase
        f.div = (CLK_HZ_TB + baud / 2) / baud;
        return f;
    endfunction

    function automatic logic line_of(input int which);
        return (which == 0) ? txd : d5_txd;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 0) ? tx_busy : d5_busy;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic record_timeout(input string name, input int budget);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got no event within %0d cycles, expected one", name, budget);
    endtask

    // Every clock of every bit must show the expected level with busy high.
    task automatic check_frame(input int which, input frame_t f);
        for (int b = 0; b < f.nbits; b++) begin
            int   bad;
            logic got;
            bad = 0;
            got = f.bits[b];
            for (int c = 0; c < f.div; c++) begin
                if (!reset) return;
                if (line_of(which) !== f.bits[b] || busy_of(which) !== 1'b1) begin
                    if (bad == 0) got = line_of(which);
                    bad++;
                end
                @(negedge clk);
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("[TB] FAIL frame_bit dut%0d bit %0d: got line %b on %0d of %0d clocks, expected %b with busy",
                         which, b, got, bad, f.div, f.bits[b]);
            end
        end
    endtask

    task automatic skip_frame(input int which);
        for (int n = 0; n < 20000 && busy_of(which) === 1'b1; n++) @(negedge clk);
    endtask

    initial begin : monitor0
        frame_t f;
        @(negedge clk);
        forever begin
            if (reset === 1'b1 && txd === 1'b0) begin
                mon_active0 = 1'b1;
                frames0++;
                starts0.push_back(cyc);
                if (exp0.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_frame dut0: got start bit at cycle %0d, expected idle line", cyc);
                    skip_frame(0);
                end else begin
                    f = exp0.pop_front();
                    check_frame(0, f);
                end
                mon_active0 = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : monitor1
        frame_t f;
        @(negedge clk);
        forever begin
            if (reset === 1'b1 && d5_txd === 1'b0) begin
                mon_active1 = 1'b1;
                frames1++;
                if (exp1.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_frame dut1: got start bit at cycle %0d, expected idle line", cyc);
                    skip_frame(1);
                end else begin
                    f = exp1.pop_front();
                    check_frame(1, f);
                end
                mon_active1 = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic expect_word(input logic [7:0] d);
        exp0.push_back(make_frame({1'b0, d}, 8, parity_mode, stop2, baud_select));
    endtask

    task automatic apply_stimulus(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && !((which == 0 ? exp0.size() : exp1.size()) == 0 &&
                               !(which == 0 ? mon_active0 : mon_active1) && !busy_of(which))) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) record_timeout(name, budget);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && frames0 < target) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) record_timeout(name, budget);
    endtask

    initial begin : watchdog
        #(1_200_000);
        $display("[TB] FAIL watchdog: got no completion, expected finish before 120000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] words[6];
        int n, s, base, f_base;

        reset = 1'b1; tx_data = '0; tx_wr = 1'b0; tx_en = 1'b0;
        d5_data = '0; d5_wr = 1'b0; d5_en = 1'b0;
        baud_select = 3'b111; parity_mode = 2'b01; stop2 = 1'b0;
        #1 reset = 1'b0;
        #2;
        check_output("reset_txd", int'(txd), 1);
        check_output("reset_busy", int'(tx_busy), 0);
        check_output("reset_full", int'(tx_full), 0);
        check_output("reset_empty", int'(tx_empty), 1);
        check_output("reset_ovf", int'(tx_ovf), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single word 0xA5, even parity, one stop");
        tx_en = 1'b1;
        expect_word(8'hA5);
        tx_data = 8'hA5; tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        check_output("lat_empty_k", int'(tx_empty), 1);
        @(negedge clk);
        check_output("lat_empty_k1", int'(tx_empty), 0);
        check_output("lat_txd_k1", int'(txd), 1);
        @(negedge clk);
        check_output("lat_txd_k2", int'(txd), 0);
        check_output("lat_busy_k2", int'(tx_busy), 1);
        n = 0;
        while (tx_busy === 1'b1 && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check_output("busy_length", n, 4774);
        wait_idle(0, 2000, "drain_single");

        $display("[TB] four back-to-back words, odd parity, two stops");
        parity_mode = 2'b10; stop2 = 1'b1;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h55; words[3] = 8'h0F;
        base = full_cycles;
        s = starts0.size();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            expect_word(words[i]);
            tx_data = words[i];
            tx_wr   = 1'b1;
            @(negedge clk);
        end
        tx_wr = 1'b0;
        wait_idle(0, 25000, "drain_burst");
        for (int i = 0; i < 3; i++) begin
            if (starts0.size() > s + i + 1)
                check_output("frame_gap", starts0[s+i+1] - starts0[s+i], 12 * 434);
            else
                record_timeout("frame_gap", 25000);
        end
        check_output("burst_never_full", full_cycles - base, 0);

        $display("[TB] six writes with transmit disabled");
        tx_en = 1'b0; parity_mode = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 6; i++) words[i] = 8'($urandom_range(0, 255));
        base = ovf_cycles;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_word(words[i]);
            tx_data = words[i];
            tx_wr   = 1'b1;
            @(negedge clk);
        end
        tx_wr = 1'b0;
        repeat (3) @(negedge clk);
        check_output("fill_full", int'(tx_full), 1);
        check_output("fill_ovf_cycles", ovf_cycles - base, 2);
        check_output("fill_busy", int'(tx_busy), 0);
        f_base = frames0;
        tx_en = 1'b1;
        wait_idle(0, 20000, "drain_fill");
        check_output("fill_frames", frames0 - f_base, 4);
        check_output("fill_empty_after", int'(tx_empty), 1);

        $display("[TB] enable dropped during D3");
        parity_mode = 2'b01; stop2 = 1'b0;
        f_base = frames0;
        expect_word(8'h3C);
        apply_stimulus(8'h3C);
        wait_frames(f_base + 1, 100, "en_drop_start");
        s = starts0[$];
        expect_word(8'hC3);
        apply_stimulus(8'hC3);
        while (cyc < s + 4 * 434 + 200) @(negedge clk);
        tx_en = 1'b0;
        while (cyc < s + 11 * 434 + 3000) @(negedge clk);
        check_output("en_drop_frames", frames0 - f_base, 1);
        check_output("en_drop_txd", int'(txd), 1);
        check_output("en_drop_busy", int'(tx_busy), 0);
        check_output("en_drop_waiting", int'(tx_empty), 0);
        tx_en = 1'b1;
        wait_idle(0, 8000, "drain_en_drop");
        check_output("en_drop_resume", frames0 - f_base, 2);

        $display("[TB] reset during DATA");
        f_base = frames0;
        expect_word(8'($urandom_range(0, 255)));
        apply_stimulus(exp0[0].bits[8:1]);
        wait_frames(f_base + 1, 100, "reset_start");
        repeat (3 * 434) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_output("async_reset_txd", int'(txd), 1);
        check_output("async_reset_busy", int'(tx_busy), 0);
        check_output("async_reset_empty", int'(tx_empty), 1);
        exp0.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        f_base = frames0;
        repeat (2000) @(negedge clk);
        check_output("post_reset_frames", frames0 - f_base, 0);
        check_output("post_reset_txd", int'(txd), 1);

        $display("[TB] five-bit instance, 0x13, no parity");
        parity_mode = 2'b00; stop2 = 1'b0;
        exp1.push_back(make_frame(9'h013, 5, parity_mode, stop2, baud_select));
        d5_en = 1'b1;
        @(negedge clk);
        d5_data = 5'h13; d5_wr = 1'b1;
        @(negedge clk);
        d5_wr = 1'b0;
        wait_idle(1, 6000, "drain_dut5");
        check_output("dut5_frames", frames1, 1);
        d5_en = 1'b0;

        $display("[TB] random words with config changed mid-frame");
        for (int i = 0; i < 3; i++) begin
            parity_mode = 2'($urandom_range(0, 3));
            stop2       = 1'($urandom_range(0, 1));
            f_base      = frames0;
            expect_word(8'($urandom_range(0, 255)));
            apply_stimulus(exp0[exp0.size()-1].bits[8:1]);
            wait_frames(f_base + 1, 7000, "random_start");
        end
        wait_idle(0, 8000, "drain_random");
        check_output("scoreboard_drain", exp0.size() + exp1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
